fir_fold_sched: RTL and testbench
=================================

# fir_fold_sched

Folded-FIR scheduler for the 16-bit → 26-bit filter path. It accepts one sample per handshake and keeps a delay line of the last TAPS samples. A single shared signed multiplier/accumulator is sequenced over all taps using runtime-loadable coefficients. The result is rounded to 26 bits (drop 5 LSBs, round-half-up) and presented on a valid/ready output. It sits alongside the fixed-coefficient direct-form filter as the programmable, low-area variant.

## Interface
- TAPS, 7, number of taps; tap index width is 3 bits.
- DW, 16, signed sample width.
- CW, 12, signed coefficient width.
- AW, 31, signed accumulator width.
- OW, 26, signed output width; OW = AW − 5.
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_data  in  DW  signed input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  3  tap index 0..TAPS−1; values ≥ TAPS are ignored.
- coef_data  in  CW  signed coefficient.
- out_data  out  OW  signed rounded filter output.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high in MAC or ROUND.

## Operation
- **State registers:**
  - delay line x[0..TAPS−1] (DW each);
  - coefficient bank c[0..TAPS−1] (CW each);
  - accumulator acc (AW);
  - tap counter k (3 bits);
  - FSM with states IDLE, MAC, ROUND, HOLD.
- **IDLE:**
  - in_ready = 1.
  - On in_valid: x[0] ← in_data and x[j] ← x[j−1] for j = 1..TAPS−1; acc ← 0; k ← 0; next state MAC.
- **MAC:**
  - Each cycle: acc ← acc + sext(x[k] × c[k]), where the product is a 28-bit signed value.
  - k ← k+1. When k = TAPS−1, next state ROUND.
- **ROUND:** out_data ← acc[30:5] + acc[4], computed mod 2^26 with no saturation; out_valid ← 1; next state HOLD.
- **HOLD:**
  - out_data is held.
  - When out_ready = 1: out_valid ← 0; next state IDLE.
- **Width:** |acc| ≤ 7·2^15·2^11 < 2^29, so acc cannot overflow. out_data cannot wrap for any inputs with TAPS = 7.
- **Coefficient writes:**
  - Accepted only in IDLE or HOLD: c[coef_addr] ← coef_data.
  - Ignored in MAC and ROUND, so a result always uses one consistent bank.
- **Simultaneous events:**
  - in_valid with coef_we in IDLE: both take effect. The new coefficient is used by the MAC pass that starts next cycle.
  - in_valid is ignored outside IDLE; the sample is not consumed because in_ready = 0.
- **Reset (rstn = 0, any state, including mid-MAC):**
  - FSM → IDLE; x, c, acc, k, out_data all 0.
  - out_valid = 0, busy = 0, in_ready = 1 (IDLE).
  - Any in-flight result is discarded.

## Timing
- Sample accepted at the edge ending cycle 0.
- MAC occupies cycles 1..7, ROUND is cycle 8, and out_valid is high from cycle 9.
- **Input-to-output latency:** 9 cycles.
- With out_ready tied high:
  - HOLD lasts 1 cycle (cycle 9) and IDLE is reached at cycle 10.
  - Sustained throughput is one sample per 10 cycles.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- out_data changes only at the ROUND edge and is stable for the whole of HOLD.

## Test plan
- **Impulse response:**
  - Stimulus: c = {32, 64, 96, 128, 160, 192, 224}; samples 1, 0, 0, 0, 0, 0, 0, 0.
  - Required: outputs 1, 2, 3, 4, 5, 6, 7, 0; each out_valid rises 9 cycles after its sample is accepted.
- **Rounding:**
  - Stimulus: c[0] = 1, others 0; samples 16, 15, −16, −17, each fed into a zeroed delay line.
  - Required: out_data = 1, 0, 0, −1.
- **Extreme magnitude:**
  - Stimulus: all c = −2048; seven samples of −32768.
  - Required: the 7th output is +14680064, with no wrap.
- **Backpressure:**
  - Stimulus: out_ready low for 20 cycles after out_valid rises.
  - Required: out_data stable; in_ready = 0; a new in_valid is not consumed. out_ready = 1 then returns the FSM to IDLE next cycle.
- **Coefficient write gating:**
  - Stimulus: coef_we to c[0] during MAC cycle 3.
  - Required: the current result uses the old c[0]; c[0] is unchanged afterwards.
  - Stimulus: the same write in HOLD.
  - Required: it takes effect for the next sample.
- **Reset mid-operation:**
  - Stimulus: rstn pulsed low during MAC cycle 4.
  - Required: out_valid = 0, busy = 0, in_ready = 1, out_data = 0 immediately. The next impulse, with all c = 0 after reset, yields out_data = 0.

Source files
------------

// File: rtl/fir_fold_sched.sv
// Folded FIR: one shared signed MAC sequenced over TAPS runtime-loadable coefficients,
// with the sum rounded half-up to OW bits and held on a valid/ready output.
module fir_fold_sched #(
    parameter int unsigned TAPS = 7,
    parameter int unsigned DW   = 16,
    parameter int unsigned CW   = 12,
    parameter int unsigned AW   = 31,
    parameter int unsigned OW   = 26
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 coef_we,
    input  logic        [2:0]    coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic signed [OW-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int unsigned PW    = DW + CW;
    localparam int unsigned RB    = AW - OW;
    localparam logic [2:0]  KLAST = 3'(TAPS - 1);
    localparam logic [2:0]  KNUM  = 3'(TAPS);

    typedef enum logic [1:0] {StIdle, StMac, StRound, StHold} state_e;

    state_e                state_q, state_d;
    logic        [2:0]     k_q, k_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [OW-1:0]  out_data_q, out_data_d;
    logic signed [DW-1:0]  x_q [TAPS];
    logic signed [DW-1:0]  x_d [TAPS];
    logic signed [CW-1:0]  c_q [TAPS];
    logic signed [CW-1:0]  c_d [TAPS];
    logic signed [PW-1:0]  prod;
    logic                  coef_ok;

    assign prod = x_q[k_q] * c_q[k_q];

    // Bank is frozen during MAC/ROUND so each result sees one consistent coefficient set.
    assign coef_ok = coef_we && (state_q == StIdle || state_q == StHold) && (coef_addr < KNUM);

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        x_d        = x_q;
        c_d        = c_q;

        if (coef_ok) begin
            c_d[coef_addr] = coef_data;
        end

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d[0] = in_data;
                    for (int j = 1; j < TAPS; j++) begin
                        x_d[j] = x_q[j-1];
                    end
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d = acc_q + {{(AW-PW){prod[PW-1]}}, prod};
                k_d   = k_q + 3'd1;
                if (k_q == KLAST) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                out_data_d = acc_q[AW-1:RB] + OW'(acc_q[RB-1]);
                state_d    = StHold;
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            k_q        <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            x_q        <= '{default: '0};
            c_q        <= '{default: '0};
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            x_q        <= x_d;
            c_q        <= c_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StHold);
    assign busy      = (state_q == StMac) || (state_q == StRound);
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_fold_sched.sv
// Self-checking bench for fir_fold_sched against an arithmetic dot-product reference model.
module tb_fir_fold_sched;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic signed [15:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               coef_we = 1'b0;
    logic        [2:0]  coef_addr = '0;
    logic signed [11:0] coef_data = '0;
    logic signed [25:0] out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    longint xm [7];
    longint cm [7];

    fir_fold_sched dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Dot product of the model delay line and bank, rounded half-up by 32.
    function automatic longint model_out();
        longint sum = 0;
        for (int i = 0; i < 7; i++) sum += xm[i] * cm[i];
        return (sum + 16) >>> 5;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 7; i++) begin
            xm[i] = 0;
            cm[i] = 0;
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Coefficient write while the DUT is known to be in IDLE or HOLD.
    task automatic write_coef(input int addr, input longint val);
        coef_we   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = 12'(val);
        @(negedge clk);
        coef_we = 1'b0;
        if (addr < 7) cm[addr] = val;
    endtask

    task automatic start_sample(input longint s, input bit we, input int addr, input longint val);
        check("in_ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = 16'(s);
        coef_we   = we;
        coef_addr = 3'(addr);
        coef_data = 12'(val);
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        cyc      = 1;
        for (int j = 6; j > 0; j--) xm[j] = xm[j-1];
        xm[0] = s;
        if (we && addr < 7) cm[addr] = val;
        check("busy_in_mac", busy, 1);
        check("in_ready_in_mac", in_ready, 0);
    endtask

    task automatic wait_result(input string tag, input longint exp);
        while (!out_valid && cyc < 40) tick();
        check({tag, "_latency"}, cyc, 9);
        check(tag, out_data, exp);
        check({tag, "_busy_hold"}, busy, 0);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        check("out_valid_after_hold", out_valid, 0);
        check("in_ready_after_hold", in_ready, 1);
    endtask

    task automatic run(input string tag, input longint s);
        start_sample(s, 1'b0, 0, 0);
        wait_result(tag, model_out());
        release_out();
    endtask

    initial begin
        longint exp_v;
        model_clear();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Impulse response, including an ignored write to address 7.
        for (int i = 0; i < 7; i++) write_coef(i, 32 * (i + 1));
        write_coef(7, 2047);
        for (int i = 0; i < 8; i++) run("impulse", (i == 0) ? 1 : 0);
        check("impulse_tap6_model", model_out(), 0);

        // Rounding: only tap 0 matters.
        for (int i = 0; i < 7; i++) write_coef(i, (i == 0) ? 1 : 0);
        run("round_16", 16);
        run("round_15", 15);
        run("round_m16", -16);
        run("round_m17", -17);

        // Extreme magnitude.
        for (int i = 0; i < 7; i++) write_coef(i, -2048);
        for (int i = 0; i < 7; i++) run("extreme", -32768);
        check("extreme_model", model_out(), 14680064);

        // Random samples, random coefficient writes, some coincident with in_valid.
        for (int i = 0; i < 7; i++) write_coef(i, longint'($signed(12'($urandom))));
        for (int n = 0; n < 12; n++) begin
            bit     we  = bit'($urandom_range(0, 1));
            int     a   = int'($urandom_range(0, 7));
            longint cv  = longint'($signed(12'($urandom)));
            longint s   = longint'($signed(16'($urandom)));
            start_sample(s, we, a, cv);
            wait_result("random", model_out());
            release_out();
        end

        // Backpressure: output held, new sample refused.
        out_ready = 1'b0;
        start_sample(1234, 1'b0, 0, 0);
        exp_v = model_out();
        wait_result("bp_result", exp_v);
        in_valid = 1'b1;
        in_data  = 16'sd999;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_stable", out_data, exp_v);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        release_out();
        run("bp_next", -77);

        // Write during MAC cycle 3 is dropped.
        start_sample(321, 1'b0, 0, 0);
        exp_v = model_out();
        tick();
        tick();
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 12'sd1000;
        tick();
        coef_we = 1'b0;
        wait_result("mac_write_ignored", exp_v);
        release_out();
        run("mac_write_c0_unchanged", 500);

        // Write during HOLD takes effect on the next sample.
        out_ready = 1'b0;
        start_sample(-400, 1'b0, 0, 0);
        wait_result("hold_pre", model_out());
        write_coef(0, 1000);
        release_out();
        run("hold_write_used", 700);

        // Asynchronous reset mid-MAC.
        start_sample(5000, 1'b0, 0, 0);
        tick();
        tick();
        tick();
        rstn = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_data", out_data, 0);
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run("post_reset_impulse", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
